mac_vetor_param: RTL and testbench



---
 rtl/mac_vetor_param.sv | 120 ++++++++++++
 tb/tb_mac_vetor_param.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_vetor_param.sv
// mac_vetor_param: streaming unsigned dot-product engine over VEC_LEN beats.
// Optional MAC_VETOR_SATURATE_EN clamps the accumulator on overflow.
module mac_vetor_param #(
  parameter int IN_W    = 10,
  parameter int ACC_W   = 22,
  parameter int VEC_LEN = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  k,
  input  logic [IN_W-1:0]  l,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] o,
  output logic             overflow
);

  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);
  localparam int PAD = ACC_W + 1 - 2 * IN_W;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] o_q, o_d;
  logic             oflag_q, oflag_d;
  logic             vld_q, vld_d;

  logic [2*IN_W-1:0] prod;
  logic [ACC_W:0]    sum;
  logic              ovf_nv;
  logic [ACC_W-1:0]  acc_nv;

  assign prod   = {{IN_W{1'b0}}, k} * {{IN_W{1'b0}}, l};
  assign sum    = {1'b0, acc_q} + {{PAD{1'b0}}, prod};
  assign ovf_nv = ovf_q | sum[ACC_W];

`ifdef MAC_VETOR_SATURATE_EN
  assign acc_nv = ovf_nv ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nv = sum[ACC_W-1:0];
`endif

  assign in_ready  = (state_q == ACCUM) && !clear;
  assign out_valid = vld_q;
  assign o         = o_q;
  assign overflow  = oflag_q;

  // Next-state: accumulate beats, latch result on the last one, hold until taken.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    o_d     = o_q;
    oflag_d = oflag_q;
    vld_d   = vld_q;
    case (state_q)
      ACCUM: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (in_valid) begin
          if (cnt_q == LAST) begin
            o_d     = acc_nv;
            oflag_d = ovf_nv;
            vld_d   = 1'b1;
            state_d = HOLD;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            acc_d = acc_nv;
            cnt_d = cnt_q + 1'b1;
            ovf_d = ovf_nv;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      o_q     <= '0;
      oflag_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      o_q     <= o_d;
      oflag_q <= oflag_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_mac_vetor_param.sv
// tb_mac_vetor_param: directed checks of the dot-product engine
// in default, narrow-accumulator and single-beat configurations.
module tb_mac_vetor_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Default configuration
  logic        a_reset, a_clear, a_iv, a_ir, a_ov, a_or, a_of;
  logic [9:0]  a_k, a_l;
  logic [21:0] a_o;

  mac_vetor_param u_a (
    .clock(clock), .reset(a_reset), .clear(a_clear),
    .in_valid(a_iv), .in_ready(a_ir), .k(a_k), .l(a_l),
    .out_valid(a_ov), .out_ready(a_or), .o(a_o), .overflow(a_of)
  );

  // ACC_W=20, VEC_LEN=2
  logic        b_reset, b_clear, b_iv, b_ir, b_ov, b_or, b_of;
  logic [9:0]  b_k, b_l;
  logic [19:0] b_o;

  mac_vetor_param #(.IN_W(10), .ACC_W(20), .VEC_LEN(2)) u_b (
    .clock(clock), .reset(b_reset), .clear(b_clear),
    .in_valid(b_iv), .in_ready(b_ir), .k(b_k), .l(b_l),
    .out_valid(b_ov), .out_ready(b_or), .o(b_o), .overflow(b_of)
  );

  // VEC_LEN=1
  logic        c_reset, c_clear, c_iv, c_ir, c_ov, c_or, c_of;
  logic [9:0]  c_k, c_l;
  logic [21:0] c_o;

  mac_vetor_param #(.IN_W(10), .ACC_W(22), .VEC_LEN(1)) u_c (
    .clock(clock), .reset(c_reset), .clear(c_clear),
    .in_valid(c_iv), .in_ready(c_ir), .k(c_k), .l(c_l),
    .out_valid(c_ov), .out_ready(c_or), .o(c_o), .overflow(c_of)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic a_beat(input int kk, input int ll);
    a_iv = 1'b1;
    a_k  = 10'(kk);
    a_l  = 10'(ll);
    step();
    a_iv = 1'b0;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    a_clear = 0; b_clear = 0; c_clear = 0;
    a_iv = 0; b_iv = 0; c_iv = 0;
    a_or = 0; b_or = 0; c_or = 0;
    a_k = 0; a_l = 0; b_k = 0; b_l = 0; c_k = 0; c_l = 0;
    step(); step();
    a_reset = 0; b_reset = 0; c_reset = 0;
    #1;
    n_checks++;
    if (a_ov !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b want 0", a_ov);
    end
    n_checks++;
    if (a_o !== 22'd0) begin
      n_fail++; $display("FAIL reset_o got %0d want 0", a_o);
    end
    n_checks++;
    if (a_of !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow got %b want 0", a_of);
    end
    n_checks++;
    if (a_ir !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", a_ir);
    end
  endtask

  task automatic test_basic();
    a_or = 1'b1;
    a_beat(3, 6);
    a_beat(4, 7);
    a_beat(5, 8);
    n_checks++;
    if (a_ov !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_valid got %b want 0", a_ov);
    end
    a_beat(1, 1);
    n_checks++;
    if (a_ov !== 1'b1 || a_o !== 22'd87 || a_of !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result got v=%b o=%0d of=%b want v=1 o=87 of=0",
               a_ov, a_o, a_of);
    end
    n_checks++;
    if (a_ir !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold_ready got %b want 0", a_ir);
    end
    step();
    n_checks++;
    if (a_ov !== 1'b0 || a_ir !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_release got v=%b ir=%b want v=0 ir=1", a_ov, a_ir);
    end
  endtask

  task automatic test_bubbles_backpressure();
    a_or = 1'b0;
    a_beat(3, 6); step();
    a_beat(4, 7); step(); step();
    a_beat(5, 8); step();
    a_beat(1, 1);
    n_checks++;
    if (a_ov !== 1'b1 || a_o !== 22'd87) begin
      n_fail++;
      $display("FAIL bubble_result got v=%b o=%0d want v=1 o=87", a_ov, a_o);
    end
    for (int i = 0; i < 5; i++) begin
      a_iv = 1'b1; a_k = 10'd9; a_l = 10'd9;
      step();
      n_checks++;
      if (a_ov !== 1'b1 || a_o !== 22'd87 || a_ir !== 1'b0) begin
        n_fail++;
        $display("FAIL bubble_hold%0d got v=%b o=%0d ir=%b want v=1 o=87 ir=0",
                 i, a_ov, a_o, a_ir);
      end
    end
    a_iv = 1'b0;
    a_or = 1'b1;
    step();
    n_checks++;
    if (a_ov !== 1'b0 || a_ir !== 1'b1) begin
      n_fail++;
      $display("FAIL bubble_release got v=%b ir=%b want v=0 ir=1", a_ov, a_ir);
    end
  endtask

  task automatic test_clear();
    a_or = 1'b1;
    a_beat(10, 10);
    a_beat(2, 2);
    a_clear = 1'b1; a_iv = 1'b1; a_k = 10'd9; a_l = 10'd9;
    #1;
    n_checks++;
    if (a_ir !== 1'b0) begin
      n_fail++; $display("FAIL clear_in_ready got %b want 0", a_ir);
    end
    step();
    a_clear = 1'b0; a_iv = 1'b0;
    a_beat(1, 1); a_beat(1, 1); a_beat(1, 1);
    n_checks++;
    if (a_ov !== 1'b0) begin
      n_fail++; $display("FAIL clear_early_valid got %b want 0", a_ov);
    end
    a_beat(1, 1);
    n_checks++;
    if (a_ov !== 1'b1 || a_o !== 22'd4 || a_of !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_result got v=%b o=%0d of=%b want v=1 o=4 of=0",
               a_ov, a_o, a_of);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    a_or = 1'b1;
    a_beat(2, 2); a_beat(2, 2);
    a_reset = 1'b1; step(); a_reset = 1'b0;
    n_checks++;
    if (a_ov !== 0 || a_o !== 0 || a_of !== 0 || a_ir !== 1) begin
      n_fail++;
      $display("FAIL rst_mid got v=%b o=%0d of=%b ir=%b want 0 0 0 1",
               a_ov, a_o, a_of, a_ir);
    end
    a_or = 1'b0;
    a_beat(5, 5); a_beat(5, 5); a_beat(5, 5); a_beat(5, 5);
    n_checks++;
    if (a_ov !== 1'b1 || a_o !== 22'd100) begin
      n_fail++;
      $display("FAIL rst_pre_hold got v=%b o=%0d want v=1 o=100", a_ov, a_o);
    end
    a_reset = 1'b1; step(); a_reset = 1'b0;
    n_checks++;
    if (a_ov !== 0 || a_o !== 0 || a_of !== 0 || a_ir !== 1) begin
      n_fail++;
      $display("FAIL rst_hold got v=%b o=%0d of=%b ir=%b want 0 0 0 1",
               a_ov, a_o, a_of, a_ir);
    end
    a_or = 1'b1;
    a_beat(2, 2); a_beat(2, 2); a_beat(2, 2);
    n_checks++;
    if (a_ov !== 1'b0) begin
      n_fail++; $display("FAIL rst_early_valid got %b want 0", a_ov);
    end
    a_beat(2, 2);
    n_checks++;
    if (a_ov !== 1'b1 || a_o !== 22'd16) begin
      n_fail++;
      $display("FAIL rst_fresh got v=%b o=%0d want v=1 o=16", a_ov, a_o);
    end
    step();
  endtask

  task automatic test_overflow();
    logic [19:0] exp_o;
`ifdef MAC_VETOR_SATURATE_EN
    exp_o = 20'd1048575;
`else
    exp_o = 20'd1044482;
`endif
    b_or = 1'b0;
    b_iv = 1'b1; b_k = 10'd1023; b_l = 10'd1023;
    step(); step();
    b_iv = 1'b0;
    n_checks++;
    if (b_ov !== 1'b1 || b_o !== exp_o || b_of !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_result got v=%b o=%0d of=%b want v=1 o=%0d of=1",
               b_ov, b_o, b_of, exp_o);
    end
    b_or = 1'b1;
    step();
    b_iv = 1'b1; b_k = 10'd2; b_l = 10'd3;
    step();
    b_k = 10'd1; b_l = 10'd1;
    step();
    b_iv = 1'b0;
    n_checks++;
    if (b_ov !== 1'b1 || b_o !== 20'd7 || b_of !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_next got v=%b o=%0d of=%b want v=1 o=7 of=0",
               b_ov, b_o, b_of);
    end
    step();
  endtask

  task automatic test_back_to_back();
    c_or = 1'b1;
    c_iv = 1'b1; c_k = 10'd7; c_l = 10'd7;
    step();
    c_k = 10'd0; c_l = 10'd5;
    n_checks++;
    if (c_ov !== 1'b1 || c_o !== 22'd49 || c_ir !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first got v=%b o=%0d ir=%b want v=1 o=49 ir=0",
               c_ov, c_o, c_ir);
    end
    step();
    n_checks++;
    if (c_ov !== 1'b0 || c_ir !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap got v=%b ir=%b want v=0 ir=1", c_ov, c_ir);
    end
    step();
    c_iv = 1'b0;
    n_checks++;
    if (c_ov !== 1'b1 || c_o !== 22'd0 || c_of !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second got v=%b o=%0d of=%b want v=1 o=0 of=0",
               c_ov, c_o, c_of);
    end
    step();
    n_checks++;
    if (c_ov !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drop got v=%b want 0", c_ov);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles_backpressure();
    test_clear();
    test_reset_midflight();
    test_overflow();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
